// File: rtl/axi4_lite_pkg.sv
// Shared constants and helpers for the AXI4-Lite register-bank slave.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int NUM_REGS_DEFAULT = 8;
    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int STRB_W           = DATA_W / 8;
    // Byte address bits below the word index; ignored for decode.
    localparam int IDX_LSB          = 2;

    // True when a byte address falls inside the register map. The two
    // byte-select bits never affect the result, so unaligned accesses
    // simply hit the containing word.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned nregs);
        return (addr >> IDX_LSB) < nregs;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register storage: one byte-strobed write port, one combinational read port.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int IDX_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Byte-lane update of the addressed register; untouched lanes keep their value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (widx_i == IDX_W'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_i[b]) begin
                            regs_q[i][8*b +: 8] <= wdata_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read sees the current (pre-write) contents, giving read-before-write
    // ordering when both ports hit the same register on one edge.
    always_comb begin
        rdata_o = regs_q[ridx_i];
    end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Write and read channels run independently; out-of-map accesses get SLVERR.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic        awready_q, awready_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic [31:0] rdata_q,   rdata_d;

    logic              aw_hs, aw_ok, ar_hs, ar_ok;
    logic [IDX_W-1:0]  widx, ridx;
    logic [31:0]       rf_rdata;

    assign widx = IDX_W'(AWADDR >> IDX_LSB);
    assign ridx = IDX_W'(ARADDR >> IDX_LSB);

    axi4_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .we_i    (aw_hs && aw_ok),
        .widx_i  (widx),
        .wdata_i (WDATA),
        .wstrb_i (WSTRB),
        .ridx_i  (ridx),
        .rdata_o (rf_rdata)
    );

    // Write channel: single shared AW/W ready pulse, then hold B until accepted.
    always_comb begin
        aw_ok     = addr_in_range(AWADDR, NUM_REGS);
        aw_hs     = AWVALID && WVALID && awready_q;
        awready_d = AWVALID && WVALID && !bvalid_q && !awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Read channel: one-cycle AR ready pulse, capture data on the handshake, hold R until accepted.
    always_comb begin
        ar_ok     = addr_in_range(ARADDR, NUM_REGS);
        ar_hs     = ARVALID && arready_q;
        arready_d = ARVALID && !rvalid_q && !arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = ar_ok ? rf_rdata : '0;
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // Channel state registers; reset drops any in-flight transaction.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = awready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Self-checking bench for axi4_lite_slave: directed scenarios plus random
// traffic compared against a simple register-array model.
module tb_axi4_lite_slave;

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int checks = 0;
    int errors = 0;

    // Reference model: eight plain 32-bit words.
    logic [31:0] mdl [8];

    axi4_lite_slave #(.NUM_REGS(8)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_map(input logic [31:0] addr);
        return addr < 32'd32;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 8) return (r * 4) | $urandom_range(0, 3);
        if (r == 8) return 32'h20 + 4 * $urandom_range(0, 7);
        return $urandom | 32'h8000_0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    endtask

    // Full write transaction; bwait cycles of BREADY low with a competing
    // AW/W offer that must not be accepted while the response is pending.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bwait);
        int n;
        logic [1:0] exp_resp;
        exp_resp = in_map(addr) ? 2'b00 : 2'b10;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        n = 0;
        @(posedge ACLK); #1;
        while (!AWREADY && n < 16) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk("wr_awready", {31'b0, AWREADY}, 32'd1);
        chk("wr_wready", {31'b0, WREADY}, 32'd1);
        chk("wr_ready_latency", n, 0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        if (in_map(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[addr[4:2]][8*b +: 8] = data[8*b +: 8];
        end
        chk("wr_awready_drop", {31'b0, AWREADY}, 32'd0);
        chk("wr_bvalid", {31'b0, BVALID}, 32'd1);
        chk("wr_bresp", {30'b0, BRESP}, {30'b0, exp_resp});
        if (bwait > 0) begin
            AWADDR = 32'h1C; WDATA = ~data; WSTRB = 4'hF;
            AWVALID = 1'b1; WVALID = 1'b1;
            for (int k = 0; k < bwait; k++) begin
                @(posedge ACLK); #1;
                chk("wr_hold_bvalid", {31'b0, BVALID}, 32'd1);
                chk("wr_hold_bresp", {30'b0, BRESP}, {30'b0, exp_resp});
                chk("wr_no_awready", {31'b0, AWREADY}, 32'd0);
            end
            AWVALID = 1'b0; WVALID = 1'b0;
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        chk("wr_bclear", {31'b0, BVALID}, 32'd0);
        BREADY = 1'b0;
    endtask

    // Full read transaction; the expected value is taken from the model at
    // call time, so a same-edge write to the same word is not yet visible.
    task automatic axi_read(input logic [31:0] addr, input int rwait);
        int n;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = in_map(addr) ? mdl[addr[4:2]] : 32'h0;
        exp_resp = in_map(addr) ? 2'b00 : 2'b10;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
        n = 0;
        @(posedge ACLK); #1;
        while (!ARREADY && n < 16) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk("rd_arready", {31'b0, ARREADY}, 32'd1);
        chk("rd_ready_latency", n, 0);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        chk("rd_arready_drop", {31'b0, ARREADY}, 32'd0);
        chk("rd_rvalid", {31'b0, RVALID}, 32'd1);
        chk("rd_rdata", RDATA, exp_data);
        chk("rd_rresp", {30'b0, RRESP}, {30'b0, exp_resp});
        if (rwait > 0) begin
            ARADDR = 32'h0; ARVALID = 1'b1;
            for (int k = 0; k < rwait; k++) begin
                @(posedge ACLK); #1;
                chk("rd_hold_rvalid", {31'b0, RVALID}, 32'd1);
                chk("rd_hold_rdata", RDATA, exp_data);
                chk("rd_hold_rresp", {30'b0, RRESP}, {30'b0, exp_resp});
                chk("rd_no_arready", {31'b0, ARREADY}, 32'd0);
            end
            ARVALID = 1'b0;
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        chk("rd_rclear", {31'b0, RVALID}, 32'd0);
        RREADY = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_awready"}, {31'b0, AWREADY}, 32'd0);
        chk({tag, "_wready"}, {31'b0, WREADY}, 32'd0);
        chk({tag, "_bvalid"}, {31'b0, BVALID}, 32'd0);
        chk({tag, "_arready"}, {31'b0, ARREADY}, 32'd0);
        chk({tag, "_rvalid"}, {31'b0, RVALID}, 32'd0);
    endtask

    initial begin
        ARESETN = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        model_reset();
        repeat (3) @(posedge ACLK);
        #1;
        check_idle("rst");
        chk("rst_bresp", {30'b0, BRESP}, 32'd0);
        chk("rst_rresp", {30'b0, RRESP}, 32'd0);
        chk("rst_rdata", RDATA, 32'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Basic writes and readback.
        axi_write(32'h00, 32'h12345678, 4'hF, 0);
        axi_write(32'h04, 32'hABCDEF01, 4'hF, 0);
        axi_read(32'h00, 0);
        axi_read(32'h04, 0);

        // Out-of-map write and read.
        axi_write(32'h20, 32'hDEADBEEF, 4'hF, 0);
        for (int i = 0; i < 8; i++) axi_read(32'(i * 4), 0);
        axi_read(32'h20, 0);

        // Partial strobes, zero strobe, unaligned address.
        axi_write(32'h08, 32'hAABBCCDD, 4'hF, 0);
        axi_write(32'h08, 32'h00001234, 4'b0011, 0);
        axi_read(32'h08, 0);
        chk("strobe_merge_model", mdl[2], 32'hAABB1234);
        axi_write(32'h08, 32'hFFFFFFFF, 4'b0000, 0);
        axi_read(32'h0B, 0);
        axi_write(32'h15, 32'hCAFEF00D, 4'hF, 0);
        axi_read(32'h14, 0);

        // Back-pressure on both response channels.
        axi_write(32'h0C, 32'h55555555, 4'hF, 5);
        axi_read(32'h0C, 0);
        axi_read(32'h10, 4);

        // Same-edge read and write to one register returns the old value.
        fork
            axi_write(32'h18, 32'h0BADC0DE, 4'hF, 0);
            axi_read(32'h18, 0);
        join
        axi_read(32'h18, 0);

        // Random traffic, including overlapped independent channels.
        for (int it = 0; it < 60; it++) begin
            int unsigned op;
            logic [31:0] wa, ra, wd;
            logic [3:0]  ws;
            int unsigned bw, rw;
            op = $urandom_range(0, 2);
            wa = rand_addr(); ra = rand_addr();
            wd = $urandom; ws = 4'($urandom_range(0, 15));
            bw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
            if (op == 0) axi_write(wa, wd, ws, int'(bw));
            else if (op == 1) axi_read(ra, int'(rw));
            else begin
                fork
                    axi_write(wa, wd, ws, int'(bw));
                    axi_read(ra, int'(rw));
                join
            end
        end
        for (int i = 0; i < 8; i++) axi_read(32'(i * 4), 0);

        // Reset while a write response is pending.
        AWADDR = 32'h1C; WDATA = 32'h77777777; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("rstmid_bvalid_before", {31'b0, BVALID}, 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check_idle("rstmid");
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < 8; i++) axi_read(32'(i * 4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave.md
# axi4_lite_slave

AXI4-Lite slave that exposes a bank of eight 32-bit read/write registers at byte offsets 0x00–0x1C. It is the memory-mapped control/status endpoint on the AXI4-Lite interconnect. It implements independent write and read paths, supports byte strobes, and returns SLVERR for out-of-range accesses.

## Interface
Parameters:
- NUM_REGS, 8, number of 32-bit registers; map spans 0x00 to 4*NUM_REGS-4.

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESETN  in  1  reset, asynchronous, active-low. Design has one clock; reset is asynchronous and active-low.
- AWADDR  in  32  write address (byte).
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accepted.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables; bit i gates WDATA[8i+7:8i].
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accepted.
- BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  master accepts response.
- ARADDR  in  32  read address (byte).
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accepted.
- RDATA  out  32  read data.
- RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  master accepts read data.

## Operation
- Reset: all registers 0; AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP = 00; RDATA = 0.
- Decode: index = ADDR[4:2]. Valid iff ADDR[31:5] == 0. ADDR[1:0] ignored; no alignment error is raised.
- Write path:
  - AWREADY and WREADY are registered and asserted together for exactly one cycle when AWVALID && WVALID && !BVALID && !AWREADY.
  - Address and data are never accepted separately.
  - On the handshake edge (AWVALID && AWREADY && WVALID && WREADY):
    - valid address: each byte i with WSTRB[i]=1 is updated; other bytes are kept; BRESP = 00.
    - invalid address: no register changes; BRESP = 10.
  - BVALID is set on that same edge and held, with BRESP stable, until BVALID && BREADY. It then clears.
  - No new write is accepted while BVALID = 1.
- Read path:
  - ARREADY is registered and asserted for one cycle when ARVALID && !RVALID && !ARREADY.
  - On the AR handshake edge, RDATA is loaded with the register value (or 0 for an invalid address). RRESP is loaded with 00 (or 10 for an invalid address). RVALID is set.
  - RDATA, RRESP and RVALID are held until RVALID && RREADY. RVALID then clears.
  - No new read is accepted while RVALID = 1.
- Read and write paths are fully independent and may complete on the same edge.
- Same-edge read and write to the same register: the read returns the pre-write value.
- WSTRB = 0000 to a valid address: OKAY response, no register change.

## Timing
- Write: AW/W valid at edge N → AWREADY/WREADY high after N → handshake at N+1 → BVALID high after N+1. Minimum of 2 cycles from valid to response.
- Read: ARVALID at edge N → ARREADY high after N → handshake at N+1 → RVALID/RDATA after N+1. Read latency is 1 cycle after the AR handshake.
- The ready pulses drop on the edge after they assert, even if the master keeps VALID high. The handshake completes on that edge.
- Back-pressure: BREADY or RREADY held low for any duration stalls only its own channel. Outputs stay stable throughout.
- Reset assertion mid-transaction immediately clears all valid/ready outputs and the registers. Any in-flight transaction is dropped.

## Structure
- Package axi4_lite_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - NUM_REGS default
  - address-decode width constants
- One sub-module, axi4_lite_regfile:
  - NUM_REGS x 32 storage
  - write port: index, data, strobe, enable
  - combinational read port: index → data
  - asynchronous reset to 0
- The top level holds the channel handshake logic.

## Test plan
- Reset, write 0x12345678 @0x00 and 0xABCDEF01 @0x04 (WSTRB=1111) → BRESP=00. Reads return those values with RRESP=00.
- Write 0xDEADBEEF @0x20 → BRESP=10, no register changes. Read @0x20 → RDATA=0, RRESP=10.
- Write 0xAABBCCDD @0x08, then 0x00001234 @0x08 with WSTRB=0011 → read @0x08 = 0xAABB1234.
- Write 0x55555555 @0x0C with BREADY low for 5 cycles → BVALID/BRESP held stable, no second AWREADY. Read @0x0C = 0x55555555.
- Hold RREADY low for 4 cycles after a read → RDATA/RVALID stable. Read @0x10 (never written) = 0x00000000.
- Assert ARESETN low while BVALID is pending → BVALID=0 immediately. All registers read back 0 afterwards.
